// File: rtl/avalon_pio_in_capture_if.sv
// rtl/avalon_pio_in_capture_if.sv - Avalon-MM slave bus bundle for the PIO input capture block
interface avalon_pio_in_capture_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/avalon_pio_in_capture.sv
// rtl/avalon_pio_in_capture.sv - Avalon-MM input PIO with synchroniser, glitch filter, edge capture and irq
module avalon_pio_in_capture #(
   parameter int WIDTH         = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 0,
   parameter int EDGE_TYPE     = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   avalon_pio_in_capture_if.slave  bus,
   input  logic [WIDTH-1:0]        in_port
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0]                  w_sync_out;
   logic [WIDTH-1:0]                  w_filtered;
   logic [WIDTH-1:0]                  r_prev;
   logic [WIDTH-1:0]                  w_edge;
   logic [WIDTH-1:0]                  r_irqmask;
   logic [WIDTH-1:0]                  r_edgecap;
   logic [WIDTH-1:0]                  w_wdata;
   logic [WIDTH-1:0]                  w_clear;
   logic [31:0]                       r_readdata;
   logic [31:0]                       w_rd_next;
   logic                              w_wr;
   logic                              w_unused;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_wr       = bus.chipselect & ~bus.write_n;
   assign w_wdata    = bus.writedata[WIDTH-1:0];
   assign w_clear    = (w_wr && bus.address == 2'd3) ? w_wdata : '0;
   // Upper writedata bits have no destination when WIDTH < 32.
   assign w_unused   = &{1'b0, bus.writedata};

   // Metastability chain: stage 0 takes the raw pin, the last stage feeds the filter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      end
   end

   generate
      if (FILTER_CYCLES == 0) begin : g_bypass
         assign w_filtered = w_sync_out;
      end else begin : g_filter
         logic [WIDTH-1:0][7:0] r_cnt;
         logic [WIDTH-1:0]      r_filt;

         // Per bit: count consecutive cycles of disagreement, flip once the run is long enough.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt  <= '0;
               r_filt <= '0;
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (w_sync_out[i] == r_filt[i]) begin
                     r_cnt[i] <= 8'd0;
                  end else if (r_cnt[i] == 8'(FILTER_CYCLES - 1)) begin
                     r_filt[i] <= ~r_filt[i];
                     r_cnt[i]  <= 8'd0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + 8'd1;
                  end
               end
            end
         end

         assign w_filtered = r_filt;
      end
   endgenerate

   // Select which transition of the filtered value counts as an event.
   always_comb begin
      w_edge = '0;
      case (EDGE_TYPE)
         0:       w_edge = w_filtered & ~r_prev;
         1:       w_edge = ~w_filtered & r_prev;
         default: w_edge = w_filtered ^ r_prev;
      endcase
   end

   // Previous filtered value for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= '0;
      end else begin
         r_prev <= w_filtered;
      end
   end

   // Sticky capture with write-1-to-clear; a fresh edge beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edgecap <= '0;
      end else begin
         r_edgecap <= (r_edgecap & ~w_clear) | w_edge;
      end
   end

   // Interrupt mask register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irqmask <= '0;
      end else if (w_wr && bus.address == 2'd2) begin
         r_irqmask <= w_wdata;
      end
   end

   // Read mux from the current address, zero-extended to the bus width.
   always_comb begin
      w_rd_next = '0;
      case (bus.address)
         2'd0:    w_rd_next[WIDTH-1:0] = w_filtered;
         2'd2:    w_rd_next[WIDTH-1:0] = r_irqmask;
         2'd3:    w_rd_next[WIDTH-1:0] = r_edgecap;
         default: w_rd_next = '0;
      endcase
   end

   // Registered read data, refreshed every cycle regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_next;
      end
   end

   assign bus.readdata = r_readdata;
   assign bus.irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_avalon_pio_in_capture.sv
// tb/tb_avalon_pio_in_capture.sv - self-checking bench for avalon_pio_in_capture
module tb_avalon_pio_in_capture;

   logic        clk;
   logic        reset_n;
   logic [7:0]  in_port;
   logic [1:0]  address;
   logic        cs;
   logic        write_n;
   logic [31:0] wdata;

   int n_pass  = 0;
   int n_total = 0;

   avalon_pio_in_capture_if bus0 ();
   avalon_pio_in_capture_if bus1 ();
   avalon_pio_in_capture_if bus2 ();

   assign bus0.address = address;  assign bus0.chipselect = cs;
   assign bus0.write_n = write_n;  assign bus0.writedata  = wdata;
   assign bus1.address = address;  assign bus1.chipselect = cs;
   assign bus1.write_n = write_n;  assign bus1.writedata  = wdata;
   assign bus2.address = address;  assign bus2.chipselect = cs;
   assign bus2.write_n = write_n;  assign bus2.writedata  = wdata;

   avalon_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(0), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port));
   avalon_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGE_TYPE(0)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port));
   avalon_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(3), .FILTER_CYCLES(0), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cfg_ss [3] = '{2, 2, 3};
   int cfg_fc [3] = '{0, 4, 0};
   int cfg_et [3] = '{0, 0, 2};

   logic [7:0]  hist [6];
   logic [7:0]  m_f1 [3];
   logic [7:0]  m_f2 [3];
   logic [7:0]  m_ec [3];
   logic [7:0]  m_mask [3];
   logic [31:0] m_rd [3];
   int          m_run [3][8];

   function automatic logic [31:0] dut_rd(int d);
      case (d)
         0:       return bus0.readdata;
         1:       return bus1.readdata;
         default: return bus2.readdata;
      endcase
   endfunction

   function automatic logic dut_irq(int d);
      case (d)
         0:       return bus0.irq;
         1:       return bus1.irq;
         default: return bus2.irq;
      endcase
   endfunction

   task automatic check32(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int j = 0; j < 6; j++) hist[j] = '0;
      for (int d = 0; d < 3; d++) begin
         m_f1[d] = '0; m_f2[d] = '0; m_ec[d] = '0; m_mask[d] = '0; m_rd[d] = '0;
         for (int b = 0; b < 8; b++) m_run[d][b] = 0;
      end
   endtask

   task automatic model_step();
      logic [7:0] fb, pb, edges, fnew, spre, slast, clr;
      logic       wr;
      for (int j = 5; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = in_port;
      wr = cs && !write_n;
      for (int d = 0; d < 3; d++) begin
         fb = m_f1[d];
         pb = m_f2[d];
         if (cfg_et[d] == 0)      edges = fb & ~pb;
         else if (cfg_et[d] == 1) edges = ~fb & pb;
         else                     edges = fb ^ pb;
         if (address == 2'd0)      m_rd[d] = {24'd0, fb};
         else if (address == 2'd2) m_rd[d] = {24'd0, m_mask[d]};
         else if (address == 2'd3) m_rd[d] = {24'd0, m_ec[d]};
         else                      m_rd[d] = 32'd0;
         clr = (wr && address == 2'd3) ? wdata[7:0] : 8'd0;
         m_ec[d] = (m_ec[d] & ~clr) | edges;
         if (wr && address == 2'd2) m_mask[d] = wdata[7:0];
         if (cfg_fc[d] == 0) begin
            fnew = hist[cfg_ss[d]-1];
         end else begin
            spre  = hist[cfg_ss[d]];
            slast = hist[cfg_ss[d]+1];
            fnew  = fb;
            for (int b = 0; b < 8; b++) begin
               if (spre[b] == slast[b]) begin
                  if (m_run[d][b] < 1000) m_run[d][b]++;
               end else begin
                  m_run[d][b] = 1;
               end
               if (spre[b] != fb[b] && m_run[d][b] >= cfg_fc[d]) fnew[b] = spre[b];
            end
         end
         m_f2[d] = m_f1[d];
         m_f1[d] = fnew;
      end
   endtask

   task automatic check_all(string tag);
      for (int d = 0; d < 3; d++) begin
         check32($sformatf("%s_rd%0d", tag, d), dut_rd(d), m_rd[d]);
         check32($sformatf("%s_irq%0d", tag, d), {31'd0, dut_irq(d)}, {31'd0, |(m_ec[d] & m_mask[d])});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      check_all("cyc");
   endtask

   task automatic bus_write(logic [1:0] a, logic [31:0] v);
      address = a; wdata = v; cs = 1'b1; write_n = 1'b0;
      tick();
      cs = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; in_port = '0; address = '0; cs = 1'b0; write_n = 1'b1; wdata = '0;
      model_reset();
      #3;
      for (int d = 0; d < 3; d++) begin
         check32($sformatf("reset_rd%0d", d), dut_rd(d), 32'd0);
         check32($sformatf("reset_irq%0d", d), {31'd0, dut_irq(d)}, 32'd0);
      end
      repeat (2) tick();
      #2 reset_n = 1'b1;
      repeat (4) tick();

      // Live data latency through a 2-stage synchroniser.
      address = 2'd0; in_port = 8'hA5;
      tick();
      tick();
      check32("t1_not_yet", bus0.readdata, 32'd0);
      tick();
      check32("t1_data", bus0.readdata, 32'h0000_00A5);
      in_port = 8'h00;
      repeat (6) tick();
      bus_write(2'd2, 32'h0000_0001);
      bus_write(2'd3, 32'hFFFF_FFFF);

      // Three pulses on bit 0, then write-1-to-clear.
      address = 2'd3;
      for (int p = 0; p < 3; p++) begin
         in_port = 8'h01; repeat (2) tick();
         in_port = 8'h00; repeat (2) tick();
      end
      repeat (4) tick();
      check32("t2_ec", bus0.readdata, 32'h1);
      check32("t2_irq", {31'd0, bus0.irq}, 32'd1);
      bus_write(2'd3, 32'h1);
      check32("t2_irq_clr", {31'd0, bus0.irq}, 32'd0);
      tick();
      check32("t2_ec_clr", bus0.readdata, 32'd0);

      // Clear lands on the same edge a new rising edge is detected.
      in_port = 8'h01;
      tick();
      tick();
      address = 2'd3; wdata = 32'h1; cs = 1'b1; write_n = 1'b0;
      tick();
      cs = 1'b0; write_n = 1'b1;
      tick();
      check32("t3_set_wins", bus0.readdata, 32'h1);
      check32("t3_irq", {31'd0, bus0.irq}, 32'd1);
      in_port = 8'h00;
      repeat (6) tick();
      bus_write(2'd3, 32'hFFFF_FFFF);

      // Glitch filter: 3-cycle pulse rejected, 6-cycle pulse accepted.
      address = 2'd0; in_port = 8'h02;
      repeat (3) tick();
      in_port = 8'h00;
      repeat (8) tick();
      check32("t4_short_data", bus1.readdata & 32'h2, 32'd0);
      address = 2'd3;
      tick();
      check32("t4_short_ec", bus1.readdata & 32'h2, 32'd0);
      address = 2'd0; in_port = 8'h02;
      repeat (6) tick();
      check32("t4_long_early", bus1.readdata & 32'h2, 32'd0);
      in_port = 8'h00;
      tick();
      check32("t4_long_data", bus1.readdata & 32'h2, 32'h2);
      repeat (8) tick();
      address = 2'd3;
      tick();
      check32("t4_long_ec", bus1.readdata & 32'h2, 32'h2);

      // Any-edge capture with the interrupt masked, then unmasked.
      bus_write(2'd2, 32'h0);
      bus_write(2'd3, 32'hFFFF_FFFF);
      in_port = 8'h80;
      repeat (6) tick();
      address = 2'd3;
      tick();
      check32("t5_ec", bus2.readdata & 32'h80, 32'h80);
      check32("t5_irq_masked", {31'd0, bus2.irq}, 32'd0);
      bus_write(2'd2, 32'h80);
      check32("t5_irq", {31'd0, bus2.irq}, 32'd1);
      in_port = 8'h00;

      // Randomised traffic on pins and bus.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
         if ($urandom_range(0, 7) == 0) in_port[$urandom_range(0, 7)] ^= 1'b1;
         address = 2'($urandom_range(0, 3));
         wdata   = $urandom;
         cs      = 1'($urandom_range(0, 1));
         write_n = ($urandom_range(0, 3) != 0);
         tick();
      end
      cs = 1'b0; write_n = 1'b1;

      // Asynchronous reset while everything is captured and enabled.
      bus_write(2'd2, 32'hFF);
      bus_write(2'd3, 32'hFF);
      in_port = 8'h00;
      repeat (8) tick();
      in_port = 8'hFF;
      repeat (10) tick();
      address = 2'd3;
      tick();
      check32("t6_ec_full", bus0.readdata, 32'hFF);
      check32("t6_irq_high", {31'd0, bus0.irq}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check32($sformatf("t6_async_rd%0d", d), dut_rd(d), 32'd0);
         check32($sformatf("t6_async_irq%0d", d), {31'd0, dut_irq(d)}, 32'd0);
      end
      model_reset();
      repeat (2) tick();
      #2 reset_n = 1'b1;
      address = 2'd2;
      tick();
      check32("t6_mask_cleared", bus0.readdata, 32'd0);
      bus_write(2'd0, 32'hFFFF_FFFF);
      bus_write(2'd1, 32'hFFFF_FFFF);
      address = 2'd1;
      tick();
      check32("t6_reserved", bus0.readdata, 32'd0);
      address = 2'd0;
      tick();
      check32("t6_data_ro", bus0.readdata, 32'hFF);
      address = 2'd3;
      tick();
      check32("t6_init_edge", bus0.readdata, 32'hFF);
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
